uart_tx_fifo: RTL

- Buffered UART transmitter peripheral core inside tinyriscv_soc_top.
- It drives the SoC's uart_tx_pin, which the simulation-side UART receive printer decodes.
- The CPU bus wrapper pushes bytes through a valid/ready port. An internal FIFO decouples software from line rate.
- A bit-timing FSM serialises 8N1 frames, LSB first.

---
 rtl/uart_tx_fifo_pkg.sv | 18 +
 rtl/uart_tx_fifo_sync_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state codes, line idle level, baud divider helper.
// The PAR state code is only reachable when UART_TX_PARITY_EN is defined.
package uart_tx_fifo_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Truncating division: the line runs slightly fast when BAUD does not divide CLK_FREQ.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock byte FIFO with push/pop, full/empty and occupancy count; synchronous active-low reset.
// Head data is read combinationally so the consumer can load it on the same edge that pops it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a bit-timing FSM, LSB first.
// Define UART_TX_PARITY_EN to add the parity_odd port and a parity bit between data and stop.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          uart_tx_pin
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                          parity_odd
`endif
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [7:0]       fifo_head;

  logic [2:0]       state_reg,   state_next;
  logic [CNT_W-1:0] baud_reg,    baud_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg,   shift_next;
  logic             pin_reg,     pin_next;
`ifdef UART_TX_PARITY_EN
  logic             par_reg,     par_next;
`endif
  logic             bit_done;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid && wr_ready),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign wr_ready = !fifo_full;
  assign tx_busy  = (state_reg != ST_IDLE);
  assign bit_done = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
`ifdef UART_TX_PARITY_EN
    par_next     = par_reg;
`endif
    fifo_pop     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
`ifdef UART_TX_PARITY_EN
          par_next   = ^fifo_head;
`endif
          state_next = ST_START;
        end
      end
      ST_START: begin
        baud_next = bit_done ? '0 : baud_reg + 1'b1;
        if (bit_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        baud_next = bit_done ? '0 : baud_reg + 1'b1;
        if (bit_done) begin
          shift_next   = shift_reg >> 1;
          bit_idx_next = bit_idx_reg + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (bit_idx_reg == 3'd7) state_next = ST_PAR;
`else
          if (bit_idx_reg == 3'd7) state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PAR: begin
        baud_next = bit_done ? '0 : baud_reg + 1'b1;
        if (bit_done) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        baud_next = bit_done ? '0 : baud_reg + 1'b1;
        // Chain straight into the next start bit so back-to-back frames have no gap.
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
`ifdef UART_TX_PARITY_EN
            par_next   = ^fifo_head;
`endif
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        baud_next  = '0;
      end
    endcase
  end

  // The pin register follows the next state so the line level changes on the same edge as the FSM.
  always_comb begin
    pin_next = UART_IDLE_LEVEL;
    case (state_next)
      ST_START: pin_next = 1'b0;
      ST_DATA:  pin_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PAR:   pin_next = par_next ^ parity_odd;
`endif
      default:  pin_next = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      pin_reg     <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      pin_reg     <= pin_next;
`ifdef UART_TX_PARITY_EN
      par_reg     <= par_next;
`endif
    end
  end

  assign uart_tx_pin = pin_reg;

endmodule
